node_sequencer: RTL and testbench

NODE_SEQUENCER -- requirements
Module: node_sequencer

---
 rtl/node_sequencer.sv | 172 +++++++++++++++++
 tb/tb_node_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/node_sequencer.sv
// Layer sequencer for a single-MAC neuron datapath: per neuron it clears the accumulator,
// streams N input/coefficient pairs, waits out the MAC latency, then strobes the result.
module node_sequencer #(
  parameter int MAX_IN    = 64,
  parameter int MAX_NODES = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       go,
  input  logic       abort,
  input  logic       hold,
  input  logic [6:0] num_inputs,
  input  logic [3:0] num_nodes,
  output logic       start,
  output logic       reset_acc,
  output logic [6:0] cnt_val,
  output logic [8:0] coef_addr,
  output logic       out_valid,
  output logic [2:0] node_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [6:0] MAX_IN_L    = 7'(MAX_IN);
  localparam logic [3:0] MAX_NODES_L = 4'(MAX_NODES);

  state_e     state_q, state_d;
  logic [6:0] n_q, n_d;
  logic [3:0] m_q, m_d;
  logic [6:0] k_q, k_d;
  logic [2:0] node_q, node_d;
  logic       start_q, start_d;
  logic       reset_acc_q, reset_acc_d;
  logic [8:0] coef_addr_q, coef_addr_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       cfg_ok_s;
  logic       last_pair_s;
  logic       last_node_s;

  assign cfg_ok_s    = (num_inputs != 7'd0) && (num_inputs <= MAX_IN_L) &&
                       (num_nodes != 4'd0) && (num_nodes <= MAX_NODES_L);
  assign last_pair_s = (k_q == (n_q - 7'd1));
  assign last_node_s = ({1'b0, node_q} == (m_q - 4'd1));

  // Outputs are registered from the next state; start_q set means pair k_q is issued this
  // cycle, clear means the current ACCUM cycle is a stall still owing pair k_q.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    k_d     = k_q;
    node_d  = node_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      k_d     = 7'd0;
      node_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go && cfg_ok_s) begin
            n_d     = num_inputs;
            m_d     = num_nodes;
            node_d  = 3'd0;
            k_d     = 7'd0;
            state_d = CLEAR;
          end else if (go) begin
            err_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          k_d     = 7'd0;
          start_d = 1'b1;
          state_d = ACCUM;
        end
        ACCUM: begin
          if (start_q && last_pair_s) begin
            state_d = DRAIN;
          end else if (start_q) begin
            k_d     = k_q + 7'd1;
            start_d = ~hold;
          end else begin
            start_d = ~hold;
          end
        end
        DRAIN: state_d = STORE;
        STORE: begin
          if (last_node_s) begin
            state_d = DONE;
          end else begin
            node_d  = node_q + 3'd1;
            k_d     = 7'd0;
            state_d = CLEAR;
          end
        end
        DONE: begin
          k_d     = 7'd0;
          node_d  = 3'd0;
          state_d = IDLE;
        end
        default: begin
          k_d     = 7'd0;
          node_d  = 3'd0;
          state_d = IDLE;
        end
      endcase
    end
    reset_acc_d = (state_d == CLEAR);
    out_valid_d = (state_d == STORE);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    coef_addr_d = {node_d, k_d[5:0]};
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      n_q         <= 7'd0;
      m_q         <= 4'd0;
      k_q         <= 7'd0;
      node_q      <= 3'd0;
      start_q     <= 1'b0;
      reset_acc_q <= 1'b0;
      coef_addr_q <= 9'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      m_q         <= m_d;
      k_q         <= k_d;
      node_q      <= node_d;
      start_q     <= start_d;
      reset_acc_q <= reset_acc_d;
      coef_addr_q <= coef_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign start     = start_q;
  assign reset_acc = reset_acc_q;
  assign cnt_val   = k_q;
  assign coef_addr = coef_addr_q;
  assign out_valid = out_valid_q;
  assign node_idx  = node_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_node_sequencer.sv
// Self-checking bench for node_sequencer: directed table, timed corner-case sequences and a
// randomized run against a trace-queue reference model.
module tb_node_sequencer;

  logic       clk = 1'b0;
  logic       n_rst, go, abort, hold;
  logic [6:0] num_inputs;
  logic [3:0] num_nodes;
  logic       start, reset_acc;
  logic [6:0] cnt_val;
  logic [8:0] coef_addr;
  logic       out_valid;
  logic [2:0] node_idx;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  node_sequencer dut (
    .clk(clk), .n_rst(n_rst), .go(go), .abort(abort), .hold(hold),
    .num_inputs(num_inputs), .num_nodes(num_nodes),
    .start(start), .reset_acc(reset_acc), .cnt_val(cnt_val), .coef_addr(coef_addr),
    .out_valid(out_valid), .node_idx(node_idx), .busy(busy), .done(done), .err(err)
  );

  // Packed output image: {start, reset_acc, cnt[6:0], coef[8:0], out_valid, node[2:0], busy, done, err}
  function automatic logic [24:0] mk(input logic s, input logic r, input logic [6:0] k,
                                     input logic [2:0] nd, input logic ov, input logic b,
                                     input logic d, input logic e);
    logic [8:0] coef;
    coef = {6'd0, nd} * 9'd64 + {2'd0, k};
    return {s, r, k, coef, ov, nd, b, d, e};
  endfunction

  // Expected outputs c cycles after the go edge of an unstalled run of m nodes by n pairs.
  function automatic logic [24:0] run_exp(input int n, input int m, input int c);
    int last, j, p;
    last = m * (n + 3) + 1;
    if (c > last) return 25'd0;
    if (c == last) return mk(1'b0, 1'b0, 7'(n - 1), 3'(m - 1), 1'b0, 1'b1, 1'b1, 1'b0);
    j = (c - 1) / (n + 3);
    p = (c - 1) % (n + 3);
    if (p == 0) return mk(1'b0, 1'b1, 7'd0, 3'(j), 1'b0, 1'b1, 1'b0, 1'b0);
    if (p <= n) return mk(1'b1, 1'b0, 7'(p - 1), 3'(j), 1'b0, 1'b1, 1'b0, 1'b0);
    if (p == n + 1) return mk(1'b0, 1'b0, 7'(n - 1), 3'(j), 1'b0, 1'b1, 1'b0, 1'b0);
    return mk(1'b0, 1'b0, 7'(n - 1), 3'(j), 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [24:0] want);
    logic [24:0] got;
    got = {start, reset_acc, cnt_val, coef_addr, out_valid, node_idx, busy, done, err};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h at t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Issues go at the current negedge and checks every cycle of the run plus one idle cycle.
  task automatic run_check(input int n, input int m, input string nm,
                           output int max_cnt, output int max_coef);
    int last, done_at;
    last = m * (n + 3) + 1;
    done_at = -1;
    max_cnt = 0;
    max_coef = 0;
    num_inputs = 7'(n);
    num_nodes = 4'(m);
    go = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      go = 1'b0;
      num_inputs = 7'($urandom_range(0, 127));
      num_nodes = 4'($urandom_range(0, 15));
      chk(nm, run_exp(n, m, c));
      if (done === 1'b1) done_at = c;
      if (int'(cnt_val) > max_cnt) max_cnt = int'(cnt_val);
      if (int'(coef_addr) > max_coef) max_coef = int'(coef_addr);
    end
    chk_int({nm, "_done_cycle"}, done_at, last);
  endtask

  typedef struct {
    logic        go;
    logic        abort;
    logic [6:0]  n;
    logic [3:0]  m;
    logic [24:0] want;
    string       nm;
  } vec_t;

  typedef struct packed {
    logic        acc;
    logic [24:0] v;
  } rec_t;

  vec_t vecs[11];
  rec_t q[$];

  initial begin
    int mc, mf, done_at, ln;
    rec_t cur, nxt;
    logic [24:0] idle_v, err_v;

    idle_v = 25'd0;
    err_v  = mk(1'b0, 1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    vecs[0]  = '{1'b1, 1'b0, 7'd0,  4'd1, err_v, "cfg_n0"};
    vecs[1]  = '{1'b1, 1'b0, 7'd4,  4'd9, err_v, "cfg_m9"};
    vecs[2]  = '{1'b1, 1'b0, 7'd65, 4'd1, err_v, "cfg_n65"};
    vecs[3]  = '{1'b1, 1'b0, 7'd4,  4'd0, err_v, "cfg_m0"};
    vecs[4]  = '{1'b0, 1'b1, 7'd4,  4'd1, idle_v, "abort_in_idle"};
    vecs[5]  = '{1'b1, 1'b0, 7'd2,  4'd1,
                 mk(1'b0, 1'b1, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0), "go_valid"};
    vecs[6]  = '{1'b1, 1'b0, 7'd0,  4'd0,
                 mk(1'b1, 1'b0, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0), "go_while_busy"};
    vecs[7]  = '{1'b0, 1'b1, 7'd2,  4'd1, idle_v, "abort_accum"};
    vecs[8]  = '{1'b1, 1'b1, 7'd64, 4'd8,
                 mk(1'b0, 1'b1, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0), "go_with_abort_idle"};
    vecs[9]  = '{1'b0, 1'b1, 7'd1,  4'd1, idle_v, "abort_clear"};
    vecs[10] = '{1'b0, 1'b0, 7'd1,  4'd1, idle_v, "idle_quiet"};

    n_rst = 1'b0;
    go = 1'b0;
    abort = 1'b0;
    hold = 1'b0;
    num_inputs = 7'd0;
    num_nodes = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", idle_v);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", idle_v);

    for (int i = 0; i < 11; i++) begin
      go = vecs[i].go;
      abort = vecs[i].abort;
      num_inputs = vecs[i].n;
      num_nodes = vecs[i].m;
      @(negedge clk);
      chk(vecs[i].nm, vecs[i].want);
    end
    go = 1'b0;
    abort = 1'b0;

    run_check(4, 2, "nominal", mc, mf);

    run_check(64, 8, "max_run", mc, mf);
    chk_int("max_coef_addr", mf, 511);
    chk_int("max_cnt_val", mc, 63);

    // Stall: hold sampled on three edges starting while pair 1 is issued.
    done_at = -1;
    num_inputs = 7'd4;
    num_nodes = 4'd1;
    go = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      go = 1'b0;
      if (c >= 4 && c <= 6) chk("stall_hold", mk(1'b0, 1'b0, 7'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      if (c == 7) chk("stall_resume", mk(1'b1, 1'b0, 7'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      if (done === 1'b1) done_at = c;
      hold = (c >= 3 && c <= 5);
    end
    hold = 1'b0;
    chk_int("stall_done_cycle", done_at, 11);

    // Abort at pair 1 of node 1.
    num_inputs = 7'd4;
    num_nodes = 4'd2;
    go = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      go = 1'b0;
      if (c <= 10) chk("abort_run", run_exp(4, 2, c));
      else chk("after_abort", idle_v);
      abort = (c == 10);
    end
    abort = 1'b0;

    // Reset mid-ACCUM.
    num_inputs = 7'd4;
    num_nodes = 4'd1;
    go = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      go = 1'b0;
      n_rst = 1'b1;
      if (c <= 3) chk("pre_reset_run", run_exp(4, 1, c));
      else if (c == 4) chk("reset_mid_accum", idle_v);
      else chk("idle_after_mid_reset", idle_v);
      if (c == 3) n_rst = 1'b0;
    end
    run_check(4, 2, "fresh_after_reset", mc, mf);

    // Randomized traffic against the trace-queue model.
    cur = '{1'b0, idle_v};
    ln = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      go = ($urandom_range(0, 3) == 0);
      num_inputs = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) num_inputs = 7'd64;
      num_nodes = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      hold = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 99) == 0);

      if (cur.v[2] == 1'b0) begin
        q.delete();
        if (go && num_inputs >= 7'd1 && num_inputs <= 7'd64 && num_nodes >= 4'd1 && num_nodes <= 4'd8) begin
          int n, m, last, p;
          n = int'(num_inputs);
          m = int'(num_nodes);
          ln = n;
          last = m * (n + 3) + 1;
          for (int c = 1; c <= last; c++) begin
            p = (c - 1) % (n + 3);
            q.push_back('{(c < last) && (p >= 1) && (p <= n), run_exp(n, m, c)});
          end
          nxt = q.pop_front();
        end else if (go) begin
          nxt = '{1'b0, err_v};
        end else begin
          nxt = '{1'b0, idle_v};
        end
      end else if (abort) begin
        q.delete();
        nxt = '{1'b0, idle_v};
      end else if (cur.acc && hold && !(cur.v[24] && int'(cur.v[22:16]) == ln - 1)) begin
        nxt = '{1'b1, mk(1'b0, 1'b0, cur.v[24] ? cur.v[22:16] + 7'd1 : cur.v[22:16],
                         cur.v[5:3], 1'b0, 1'b1, 1'b0, 1'b0)};
      end else if (q.size() > 0) begin
        nxt = q.pop_front();
      end else begin
        nxt = '{1'b0, idle_v};
      end

      @(negedge clk);
      cur = nxt;
      chk("random", cur.v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
